// File: rtl/cheri_lsu_bg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cheri_lsu_bg_arbiter
// Purpose  : Round-robin arbiter sharing the single background LSU request
//            port between NMstr background engines. It holds the grant from
//            request until lsu_req_done_i. It also routes each in-order LSU
//            response back to the engine that issued it, using a small tag
//            FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mstr_req_i[NMstr]      per-engine request, held until its req_done
//   mstr_is_cap_i/we_i     per-engine access attributes
//   mstr_addr_i            engine i at [32i+31:32i]
//   mstr_wdata_i           engine i at [33i+32:33i]
//   mstr_req_done_o        one-hot pulse: engine's request accepted
//   mstr_resp_valid_o      one-hot pulse: response belongs to engine
//   lsu_req_o, lsu_*_o     muxed request towards the LSU
//   lsu_req_done_i         LSU accepted the current request
//   lsu_resp_valid_i       LSU response strobe (data on shared bus)
//   busy_o                 grant locked or responses outstanding
//   resp_err_o             sticky: response arrived with nothing outstanding
// ============================================================================
module cheri_lsu_bg_arbiter #(
  parameter int NMstr     = 2,
  parameter int MaxOutstd = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NMstr-1:0]      mstr_req_i,
  input  logic [NMstr-1:0]      mstr_is_cap_i,
  input  logic [NMstr-1:0]      mstr_we_i,
  input  logic [NMstr*32-1:0]   mstr_addr_i,
  input  logic [NMstr*33-1:0]   mstr_wdata_i,
  output logic [NMstr-1:0]      mstr_req_done_o,
  output logic [NMstr-1:0]      mstr_resp_valid_o,
  output logic                  lsu_req_o,
  output logic                  lsu_is_cap_o,
  output logic                  lsu_we_o,
  output logic [31:0]           lsu_addr_o,
  output logic [32:0]           lsu_wdata_o,
  input  logic                  lsu_req_done_i,
  input  logic                  lsu_resp_valid_i,
  output logic                  busy_o,
  output logic                  resp_err_o
);

  localparam int IdxW = $clog2(NMstr);
  localparam int PtrW = (MaxOutstd > 1) ? $clog2(MaxOutstd) : 1;
  localparam int CntW = $clog2(MaxOutstd + 1);

  logic [IdxW-1:0] rr_ptr;
  logic            lock_q;
  logic [NMstr-1:0] gnt_q;
  logic [NMstr-1:0] win;
  logic [NMstr-1:0] gnt;
  logic [IdxW-1:0] gnt_idx;
  logic            found;

  logic [IdxW-1:0] fifo_mem [MaxOutstd];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IdxW-1:0] head;
  logic            accept;
  logic            pop;

  // Round-robin scan from rr_ptr upwards, then wrap to the indices below it.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NMstr; i++) begin
      if (!found && (IdxW'(i) >= rr_ptr) && mstr_req_i[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NMstr; i++) begin
      if (!found && (IdxW'(i) < rr_ptr) && mstr_req_i[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // While reset is asserted the grant is forced off so every LSU-facing
  // output reads 0 even if engines keep their requests raised.
  assign gnt = rst_ni ? (lock_q ? gnt_q : win) : '0;

  always_comb begin
    gnt_idx      = '0;
    lsu_is_cap_o = 1'b0;
    lsu_we_o     = 1'b0;
    lsu_addr_o   = '0;
    lsu_wdata_o  = '0;
    for (int i = 0; i < NMstr; i++) begin
      if (gnt[i]) begin
        gnt_idx = gnt_idx | IdxW'(i);
      end
      lsu_is_cap_o = lsu_is_cap_o | (gnt[i] & mstr_is_cap_i[i]);
      lsu_we_o     = lsu_we_o | (gnt[i] & mstr_we_i[i]);
      lsu_addr_o   = lsu_addr_o | ({32{gnt[i]}} & mstr_addr_i[32*i +: 32]);
      lsu_wdata_o  = lsu_wdata_o | ({33{gnt[i]}} & mstr_wdata_i[33*i +: 33]);
    end
  end

  assign fifo_full  = (count == CntW'(MaxOutstd));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // A full FIFO suppresses the request without locking, so arbitration is
  // redone from scratch once a response frees a slot.
  assign lsu_req_o = (|gnt) & ~fifo_full;
  assign accept    = lsu_req_o & lsu_req_done_i;
  assign pop       = lsu_resp_valid_i & ~fifo_empty;

  assign mstr_req_done_o = accept ? gnt : '0;
  assign busy_o          = lock_q | ~fifo_empty;

  always_comb begin
    mstr_resp_valid_o = '0;
    for (int i = 0; i < NMstr; i++) begin
      mstr_resp_valid_o[i] = pop & (head == IdxW'(i));
    end
  end

  // Grant lock and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else if (lsu_req_o) begin
      if (lsu_req_done_i) begin
        lock_q <= 1'b0;
        rr_ptr <= (gnt_idx == IdxW'(NMstr - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        lock_q <= 1'b1;
        gnt_q  <= gnt;
      end
    end
  end

  // Response-routing tag FIFO and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_o <= 1'b0;
      for (int i = 0; i < MaxOutstd; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= gnt_idx;
        wr_ptr <= (wr_ptr == PtrW'(MaxOutstd - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrW'(MaxOutstd - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
      if (lsu_resp_valid_i && fifo_empty) begin
        resp_err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cheri_lsu_bg_arbiter.md
Name: cheri_lsu_bg_arbiter

Overview:
Round-robin arbiter that shares the single background LSU request port between NMstr background engines (e.g. tag-revocation sweeper, stack zeroiser, future engines).
- Locks the grant from request until `lsu_req_done_i`.
- Tracks outstanding accesses in an in-order tag FIFO so each LSU response is routed back to the engine that issued it.
- Sits between the engines and the LSU's background request/response interface.

Parameters:
- NMstr, 2, number of requesting engines (2..8).
- MaxOutstd, 2, maximum accepted-but-unanswered accesses (1..4). This is the depth of the response-routing FIFO.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- mstr_req_i  in  NMstr  per-engine request; held until its req_done
- mstr_is_cap_i  in  NMstr  per-engine capability-width access
- mstr_we_i  in  NMstr  per-engine write enable
- mstr_addr_i  in  NMstr*32  per-engine address; engine i at bits [32i+31:32i]
- mstr_wdata_i  in  NMstr*33  per-engine write data; engine i at bits [33i+32:33i]
- mstr_req_done_o  out  NMstr  one-hot pulse: engine's request accepted by LSU
- mstr_resp_valid_o  out  NMstr  one-hot pulse: response for engine
- lsu_req_o  out  1  request to LSU
- lsu_is_cap_o  out  1  muxed is_cap
- lsu_we_o  out  1  muxed we
- lsu_addr_o  out  32  muxed address
- lsu_wdata_o  out  33  muxed write data
- lsu_req_done_i  in  1  LSU accepted current request
- lsu_resp_valid_i  in  1  LSU response (data/err carried on shared bus, not muxed here)
- busy_o  out  1  grant locked or FIFO non-empty
- resp_err_o  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset values:
  - All outputs 0.
  - rr_ptr = 0, lock_q = 0, gnt_q = 0.
  - FIFO empty; resp_err_o = 0.
- Arbitration (combinational):
  - Scan engines starting at rr_ptr, wrapping modulo NMstr.
  - The first engine with mstr_req_i set wins; `win` is one-hot.
- Effective grant:
  - gnt = lock_q ? gnt_q : win.
  - lsu_* control, address and data are muxed by gnt; all 0 when gnt = 0.
- lsu_req_o:
  - Equals (|gnt) & ~fifo_full.
  - When the FIFO is full, lsu_req_o = 0 and no grant is locked. The arbitration decision is re-made once space frees.
- Lock:
  - If lsu_req_o = 1 and lsu_req_done_i = 0, then next cycle lock_q = 1 and gnt_q = gnt.
  - Address, data and control stay stable until done even if a higher-priority engine raises a request.
  - On lsu_req_done_i: lock_q clears; mstr_req_done_o = gnt in the same cycle; rr_ptr <= (index(gnt) + 1) mod NMstr.
  - Back-to-back: a new arbitration may issue in the cycle after done. Zero idle cycles are required when the FIFO has space.
- lsu_req_done_i while lsu_req_o = 0: ignored (no pulse, no push).
- FIFO:
  - On accepted done, push index(gnt) ($clog2(NMstr) bits).
  - On lsu_resp_valid_i with FIFO non-empty: pop the head; mstr_resp_valid_o[head] = 1 in the same cycle (combinational routing).
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Responses return in issue order; the LSU guarantees this.
- lsu_resp_valid_i with FIFO empty: no mstr_resp_valid_o; resp_err_o set sticky until reset.
- Engine dropping mstr_req_i while locked: protocol violation. The arbiter keeps driving the locked request; no recovery is defined.
- Reset mid-transaction clears the lock and the FIFO immediately; in-flight responses after reset are flagged via resp_err_o.
- Latency: request-to-LSU 0 cycles from mstr_req_i when unlocked and the FIFO is not full; response routing 0 cycles.

Test Plan:
- Single engine: NMstr=2, engine 1 requests addr 0x2000_0040, we=1, wdata 0x1_DEAD_BEEF.
  -> lsu_addr_o = 0x2000_0040 in the same cycle; lsu_req_done_i in cycle 3 -> mstr_req_done_o = 2'b10.
  -> Response 2 cycles later -> mstr_resp_valid_o = 2'b10.
- Contention: both engines request continuously, done every cycle.
  -> Grants alternate 0,1,0,1; rr_ptr toggles; each engine gets 4 of 8 accepts.
- Lock hold: engine 1 granted, done delayed 5 cycles, engine 0 raises a request in cycle 2.
  -> lsu_addr_o stays engine 1's value for all 5 cycles; engine 0 is granted the cycle after done.
- Backpressure: MaxOutstd=2, two accepts with no responses.
  -> lsu_req_o = 0 despite pending requests.
  -> One response arrives -> lsu_req_o reasserts next cycle; the response goes to the first issuer.
- Same-cycle push and pop with FIFO occupancy 1: done and resp in the same cycle.
  -> Occupancy stays 1; resp routed to the old head; the new tag is the new head.
- Error and reset: lsu_resp_valid_i pulse with FIFO empty -> resp_err_o = 1 and stays set; assert rst_ni low mid-lock -> all outputs 0 and the FIFO empty.
